microcode_store_loader: RTL

// - Writer side of the microcode control store: the sequencer reads control words at u_address; this block fills the writable store before/while the CPU is held.
// - Accepts a framed byte stream (valid/ready) from the boot/host link and assembles CW_BYTES bytes per control word.
// - Writes each control word at an incrementing u_address, verifies a trailing checksum, and reports done/err.

---
 rtl/pa_microcode.sv | 19 +
 rtl/ucode_word_assembler.sv | 40 ++++
 rtl/microcode_store_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pa_microcode.sv
// Shared microcode-store types: loader FSM states and frame constants.
package pa_microcode;

    typedef enum logic [3:0] {
        LS_IDLE,
        LS_ADDR_LO,
        LS_ADDR_HI,
        LS_CNT_LO,
        LS_CNT_HI,
        LS_DATA,
        LS_WRITE,
        LS_CHECK,
        LS_DONE
    } e_loader_state;

    localparam logic [7:0] LOADER_SYNC      = 8'hA5;
    localparam int         LOADER_HDR_BYTES = 4;

endpackage

// File: rtl/ucode_word_assembler.sv
// Collects CW_BYTES stream bytes into one control word, first byte ending up in bits [7:0].
module ucode_word_assembler #(
    parameter int CW_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    clr,
    input  logic                    shift_en,
    input  logic [7:0]              byte_in,
    output logic [8*CW_BYTES-1:0]   word_out,
    output logic                    word_full
);

    localparam int               IDX_W    = (CW_BYTES > 1) ? $clog2(CW_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CW_BYTES - 1);

    logic [IDX_W-1:0]        byte_idx;
    logic [8*CW_BYTES+7:0]   shifted;

    // New bytes enter at the top and move down, so after CW_BYTES shifts the first one sits at [7:0].
    assign shifted   = {byte_in, word_out} >> 8;
    assign word_full = (byte_idx == LAST_IDX);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            word_out <= '0;
            byte_idx <= '0;
        end else begin
            if (shift_en) begin
                word_out <= shifted[8*CW_BYTES-1:0];
            end
            if (clr) begin
                byte_idx <= '0;
            end else if (shift_en) begin
                byte_idx <= word_full ? '0 : byte_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/microcode_store_loader.sv
// Loads framed control words from the boot link into the writable control store,
// holding the CPU while a frame is in flight and checking a trailing 8-bit checksum.
module microcode_store_loader
    import pa_microcode::*;
#(
    parameter int ADDR_W   = 14,
    parameter int CW_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    abort,
    output logic                    cs_we,
    output logic [ADDR_W-1:0]       cs_addr,
    output logic [8*CW_BYTES-1:0]   cs_wdata,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    e_loader_state      state;
    e_loader_state      state_next;
    logic [ADDR_W-1:0]  addr;
    logic [15:0]        remaining;
    logic [7:0]         hdr_lo;
    logic [7:0]         sum;
    logic [7:0]         sum_next;
    logic [15:0]        hdr_word;
    logic               accept;
    logic               word_full;
    logic               last_word;
    logic               addr_overflow;

    assign accept        = in_valid & in_ready;
    assign hdr_word      = {in_data, hdr_lo};
    assign sum_next      = sum + in_data;
    assign last_word     = (remaining == 16'd1);
    assign addr_overflow = !last_word && (addr == ADDR_MAX);
    assign cs_addr       = addr;

    ucode_word_assembler #(.CW_BYTES(CW_BYTES)) u_asm (
        .clk      (clk),
        .arst     (arst),
        .clr      (abort || state == LS_IDLE),
        .shift_en (accept && !abort && state == LS_DATA),
        .byte_in  (in_data),
        .word_out (cs_wdata),
        .word_full(word_full)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= LS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = LS_IDLE;
        end else begin
            case (state)
                LS_IDLE:    if (accept && in_data == LOADER_SYNC) state_next = LS_ADDR_LO;
                LS_ADDR_LO: if (accept) state_next = LS_ADDR_HI;
                LS_ADDR_HI: if (accept) state_next = LS_CNT_LO;
                LS_CNT_LO:  if (accept) state_next = LS_CNT_HI;
                LS_CNT_HI:  if (accept) state_next = (hdr_word == 16'd0) ? LS_CHECK : LS_DATA;
                LS_DATA:    if (accept && word_full) state_next = LS_WRITE;
                LS_WRITE: begin
                    if (last_word)          state_next = LS_CHECK;
                    else if (addr_overflow) state_next = LS_DONE;
                    else                    state_next = LS_DATA;
                end
                LS_CHECK:   if (accept) state_next = LS_DONE;
                LS_DONE:    state_next = LS_IDLE;
                default:    state_next = LS_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b1;
        cs_we    = 1'b0;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            LS_IDLE: begin
                cpu_hold = 1'b0;
                busy     = 1'b0;
            end
            LS_WRITE: begin
                in_ready = 1'b0;
                cs_we    = 1'b1;
            end
            LS_DONE: begin
                in_ready = 1'b0;
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            default: ;
        endcase
    end

    // Header capture, address/word counters and the running checksum over every byte after SYNC.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            addr      <= '0;
            remaining <= '0;
            hdr_lo    <= '0;
            sum       <= '0;
            err       <= 1'b0;
        end else if (abort) begin
            if (state != LS_IDLE) err <= 1'b1;
        end else begin
            case (state)
                LS_IDLE: if (accept && in_data == LOADER_SYNC) begin
                    err <= 1'b0;
                    sum <= '0;
                end
                LS_ADDR_LO, LS_CNT_LO: if (accept) begin
                    hdr_lo <= in_data;
                    sum    <= sum_next;
                end
                LS_ADDR_HI: if (accept) begin
                    addr <= hdr_word[ADDR_W-1:0];
                    sum  <= sum_next;
                end
                LS_CNT_HI: if (accept) begin
                    remaining <= hdr_word;
                    sum       <= sum_next;
                end
                LS_DATA: if (accept) sum <= sum_next;
                LS_WRITE: begin
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 16'd1;
                    if (addr_overflow) err <= 1'b1;
                end
                LS_CHECK: if (accept) begin
                    sum <= sum_next;
                    if (sum_next != 8'd0) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
